// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitStart,
        StWaitDone
    } arb_state_e;

    // Index width for n items; never less than 1 so single-entry vectors stay legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [NREQ-1:0]  onehot_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        int unsigned cand;
        valid_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        cand     = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = (32'(ptr_i) + i) % NREQ;
            if (!valid_o && req_i[IDX_W'(cand)]) begin
                valid_o                 = 1'b1;
                onehot_o[IDX_W'(cand)] = 1'b1;
                idx_o                   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NREQ byte producers.
// Define UART_ARB_PACKET_LOCK_EN to hold the grant on one requester until its req_last byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned IDX_W         = clog2(NREQ),
    parameter int unsigned START_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]             req_last,
    output logic [NREQ-1:0]             req_ready,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        send,
    output logic [UART_BYTE_W-1:0]      tx_data,
    input  logic                        tx_busy,
    output logic                        timeout_err
);

    localparam int unsigned     CNT_W   = clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(START_TIMEOUT);

    arb_state_e             state_q, state_d;
    logic                   send_q, send_d;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                   tout_q, tout_d;

    logic [NREQ-1:0]        pick_mask;
    logic                   pick_valid;
    logic [NREQ-1:0]        pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic [UART_BYTE_W-1:0] pick_data;

`ifdef UART_ARB_PACKET_LOCK_EN
    logic            lock_q, lock_d;
    logic [NREQ-1:0] lock_onehot;

    // ptr_q always names the last winner, i.e. the requester holding the lock.
    assign lock_onehot = NREQ'(1) << ptr_q;
    assign pick_mask   = lock_q ? (req_valid & lock_onehot) : req_valid;
`else
    logic unused_last;

    assign unused_last = ^req_last;
    assign pick_mask   = req_valid;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDX_W(IDX_W)
    ) u_pick (
        .req_i   (pick_mask),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .onehot_o(pick_onehot),
        .idx_o   (pick_idx)
    );

    always_comb begin
        pick_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) pick_data = pick_data | req_data[i*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        send_d    = 1'b0;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tout_d    = 1'b0;
`ifdef UART_ARB_PACKET_LOCK_EN
        lock_d    = lock_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    tx_data_d = pick_data;
                    grant_d   = pick_idx;
                    ptr_d     = pick_idx;
                    send_d    = 1'b1;
                    state_d   = StSend;
`ifdef UART_ARB_PACKET_LOCK_EN
                    lock_d    = ~|(req_last & pick_onehot);
`endif
                end
            end
            StSend: begin
                cnt_d   = '0;
                state_d = StWaitStart;
            end
            StWaitStart: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else begin
                    cnt_d = cnt_inc;
                    // Give up on a transmitter that never acknowledged the byte.
                    if (cnt_inc == CNT_MAX) begin
                        tout_d  = 1'b1;
                        state_d = StIdle;
`ifdef UART_ARB_PACKET_LOCK_EN
                        lock_d  = 1'b0;
`endif
                    end
                end
            end
            StWaitDone: begin
                if (!tx_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            send_q    <= 1'b0;
            tx_data_q <= '0;
            grant_q   <= '0;
            ptr_q     <= IDX_W'(NREQ - 1);
            cnt_q     <= '0;
            tout_q    <= 1'b0;
`ifdef UART_ARB_PACKET_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            send_q    <= send_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            tout_q    <= tout_d;
`ifdef UART_ARB_PACKET_LOCK_EN
            lock_q    <= lock_d;
`endif
        end
    end

    assign req_ready   = (state_q == StIdle) ? pick_onehot : '0;
    assign grant_idx   = grant_q;
    assign send        = send_q;
    assign tx_data     = tx_data_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART busy model.
// Packet-lock expectations follow UART_ARB_PACKET_LOCK_EN.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [1:0]  grant_idx;
    logic        send;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;
    int busy_len = 10;
    bit busy_en = 1'b1;
    int n;
    int grants[$];
    int exp_q[$];

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_idx;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[9];
    vec_t pkt_setup;

    uart_tx_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant_idx  (grant_idx),
        .send       (send),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // UART model: busy for busy_len cycles starting the cycle after send.
    always @(posedge clk) begin
        if (!rst_n) busy_cnt <= 0;
        else if (send && busy_en) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        step();
        @(negedge clk);
        check("rst_send", 32'(send), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_grant", 32'(grant_idx), 0);
        check("rst_txdata", 32'(tx_data), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        step();
        rst_n = 1'b1;
    endtask

    // Returns at a negedge where busy is low; the arbiter is back in idle on the next edge.
    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (tx_busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("idle_wait", 32'(tx_busy), 0);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        step();
        req_valid = v.valid;
        req_data = v.data;
        @(negedge clk);
        check($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(v.exp_ready));
        step();
        req_valid = '0;
        @(negedge clk);
        check($sformatf("vec%0d_send", k), 32'(send), 1);
        check($sformatf("vec%0d_txdata", k), 32'(tx_data), 32'(v.exp_byte));
        check($sformatf("vec%0d_grant", k), 32'(grant_idx), 32'(v.exp_idx));
        wait_idle();
    endtask

    // mode 0: requester drops valid once granted; 1: all hold; 2: requester 1 sends a 3-byte packet.
    task automatic collect(input int mode, input int cycles, input int stop_after, input int gap);
        logic [3:0] got;
        logic [3:0] prev;
        logic [7:0] exp_byte;
        int last_cyc;
        int pkt_k;
        int gi;
        prev = '0;
        exp_byte = '0;
        last_cyc = -1;
        pkt_k = 0;
        grants.delete();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            got = req_ready;
            check("send_pulse", 32'(send), 32'(prev != 0));
            if (prev != 0) check("coll_txdata", 32'(tx_data), 32'(exp_byte));
            if (got != 0) begin
                check("ready_onehot", 32'($countones(got)), 1);
                gi = $clog2(got);
                grants.push_back(gi);
                exp_byte = req_data[8*gi +: 8];
                if (gap > 0 && last_cyc >= 0) check("grant_gap", 32'(c - last_cyc), 32'(gap));
                last_cyc = c;
            end
            prev = got;
            step();
            if (got != 0) begin
                if (mode == 0) req_valid = req_valid & ~got;
                if (mode == 2 && got[1]) begin
                    pkt_k++;
                    if (pkt_k >= 3) begin
                        req_valid[1] = 1'b0;
                        req_last[1] = 1'b0;
                    end else begin
                        req_data[15:8] = 8'h50 + 8'(pkt_k);
                        req_last[1] = (pkt_k == 2);
                    end
                end
                if (grants.size() == stop_after) begin
                    req_valid = '0;
                    req_last = '0;
                end
            end
        end
    endtask

    task automatic check_grants(input string name);
        check({name, "_count"}, 32'(grants.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < grants.size()) check($sformatf("%s[%0d]", name, i), 32'(grants[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        vecs[0] = '{4'b0001, 32'h0000_0031, 4'b0001, 2'd0, 8'h31};
        vecs[1] = '{4'b1111, 32'h4443_4241, 4'b0010, 2'd1, 8'h42};
        vecs[2] = '{4'b1111, 32'h4443_4241, 4'b0100, 2'd2, 8'h43};
        vecs[3] = '{4'b1111, 32'h4443_4241, 4'b1000, 2'd3, 8'h44};
        vecs[4] = '{4'b1111, 32'h4443_4241, 4'b0001, 2'd0, 8'h41};
        vecs[5] = '{4'b1001, 32'hA0B0_C0D0, 4'b1000, 2'd3, 8'hA0};
        vecs[6] = '{4'b0011, 32'h0000_1122, 4'b0001, 2'd0, 8'h22};
        vecs[7] = '{4'b0110, 32'h0033_4400, 4'b0010, 2'd1, 8'h44};
        vecs[8] = '{4'b0100, 32'h0055_0000, 4'b0100, 2'd2, 8'h55};
        pkt_setup = '{4'b0001, 32'h0000_0060, 4'b0001, 2'd0, 8'h60};

        do_reset();
        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Pointer at 2, requesters 0 and 1 hold until served: 0 then 1, nothing else.
        step();
        req_valid = 4'b0011;
        req_data = 32'h0000_2211;
        collect(0, 50, 99, 13);
        exp_q = '{0, 1};
        check_grants("ptr2_order");

        // Transmitter never goes busy: abandon after the start timeout, then grant normally.
        busy_en = 1'b0;
        step();
        req_valid = 4'b0001;
        req_data = 32'h0000_0077;
        @(negedge clk);
        check("to_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("to_send", 32'(send), 1);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (timeout_err) break;
        end
        check("to_delay", 32'(n), 16);
        busy_en = 1'b1;
        step();
        req_valid = 4'b0010;
        req_data = 32'h0000_8800;
        @(negedge clk);
        check("to_pulse_len", 32'(timeout_err), 0);
        check("to_regrant", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        @(negedge clk);
        check("to_regrant_send", 32'(send), 1);
        check("to_regrant_data", 32'(tx_data), 32'h88);
        wait_idle();

        // Reset while waiting for busy to fall.
        step();
        req_valid = 4'b0100;
        req_data = 32'h00AB_0000;
        @(negedge clk);
        check("wd_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        repeat (4) @(negedge clk);
        check("wd_busy", 32'(tx_busy), 1);
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        check("wd_send", 32'(send), 0);
        check("wd_ready0", 32'(req_ready), 0);
        check("wd_grant", 32'(grant_idx), 0);
        check("wd_txdata", 32'(tx_data), 0);
        step();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        req_data = 32'h4443_4241;
        @(negedge clk);
        check("wd_first", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("wd_first_data", 32'(tx_data), 32'h41);
        wait_idle();

        // All four continuously valid from reset.
        do_reset();
        step();
        req_valid = 4'b1111;
        req_data = 32'h4443_4241;
        collect(1, 90, 6, 13);
        exp_q = '{0, 1, 2, 3, 0, 1};
        check_grants("rr_order");

        // Requester 1 sends a 3-byte packet while requester 0 stays valid.
        busy_len = 2;
        do_reset();
        run_vec(pkt_setup, 9);
        step();
        req_valid = 4'b0011;
        req_data = 32'h0000_5070;
        req_last = 4'b0000;
`ifdef UART_ARB_PACKET_LOCK_EN
        collect(2, 40, 4, 5);
        exp_q = '{1, 1, 1, 0};
`else
        collect(2, 40, 5, 5);
        exp_q = '{1, 0, 1, 0, 1};
`endif
        check_grants("pkt_order");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
